// File: rtl/timer_ctrl_if.sv
// Control/status bundle for timer_ctrl.
//   master : control source (drives start/stop/pause/mode/limit/presc,
//            observes count/tick/done/busy/state)
//   slave  : the timer sequencer itself
interface timer_ctrl_if #(
    parameter int N = 4,
    parameter int P = 4
);
    logic         start;
    logic         stop;
    logic         pause;
    logic         mode;
    logic [N-1:0] limit;
    logic [P-1:0] presc;
    logic [N-1:0] count;
    logic         tick;
    logic         done;
    logic         busy;
    logic [1:0]   state;

    modport master (
        output start, stop, pause, mode, limit, presc,
        input  count, tick, done, busy, state
    );

    modport slave (
        input  start, stop, pause, mode, limit, presc,
        output count, tick, done, busy, state
    );
endinterface

// File: rtl/timer_ctrl.sv
// timer_ctrl: prescaled N-bit up-counter sequencer with start/stop/pause,
// programmable terminal value and one-shot or periodic (auto-reload) mode.
//   clk     : clock, rising edge
//   arst_n  : active-low reset, sampled on the rising clock edge
//   bus     : timer_ctrl_if.slave
//             in  start, stop, pause, mode, limit[N], presc[P]
//             out count[N], tick, done, busy, state[2]
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | stopped, count cleared, waiting for start
// RUN   | prescaler running, count advances on each prescaler wrap
// HOLD  | paused, prescaler and count frozen
// DONE  | one-shot finished, count holds limit until start/stop
module timer_ctrl #(
    parameter int N = 4,
    parameter int P = 4
) (
    input  logic              clk,
    input  logic              arst_n,
    timer_ctrl_if.slave       bus
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10,
        DONE = 2'b11
    } state_t;

    localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};
    localparam logic [P-1:0] PRE_ONE = {{(P-1){1'b0}}, 1'b1};

    state_t       state_q, state_d;
    logic [N-1:0] count_q, count_d;
    logic [P-1:0] pre_q,   pre_d;
    logic [N-1:0] limit_q, limit_d;
    logic [P-1:0] presc_q, presc_d;
    logic         mode_q,  mode_d;
    logic         tick_q,  tick_d;
    logic         done_q,  done_d;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pre_d   = pre_q;
        limit_d = limit_q;
        presc_d = presc_q;
        mode_d  = mode_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;

        if (bus.stop) begin
            state_d = IDLE;
            count_d = '0;
            pre_d   = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_d = RUN;
                        count_d = '0;
                        pre_d   = '0;
                        limit_d = bus.limit;
                        presc_d = bus.presc;
                        mode_d  = bus.mode;
                    end
                end
                RUN: begin
                    // start is ignored here; pause freezes without ticking
                    if (bus.pause) begin
                        state_d = HOLD;
                    end else if (pre_q == presc_q) begin
                        pre_d  = '0;
                        tick_d = 1'b1;
                        if (count_q == limit_q) begin
                            done_d = 1'b1;
                            if (mode_q) begin
                                count_d = '0;
                            end else begin
                                state_d = DONE;
                            end
                        end else begin
                            count_d = count_q + CNT_ONE;
                        end
                    end else begin
                        pre_d = pre_q + PRE_ONE;
                    end
                end
                HOLD: begin
                    // resume edge does not advance the prescaler
                    if (!bus.pause) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            pre_q   <= '0;
            limit_q <= '0;
            presc_q <= '0;
            mode_q  <= 1'b0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pre_q   <= pre_d;
            limit_q <= limit_d;
            presc_q <= presc_d;
            mode_q  <= mode_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    assign bus.count = count_q;
    assign bus.tick  = tick_q;
    assign bus.done  = done_q;
    assign bus.busy  = (state_q == RUN) || (state_q == HOLD);
    assign bus.state = state_q;
endmodule
